// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the instruction/data cache memory-port arbiter:
// FSM states, requester ids, exception bit positions and a one-hot helper.
package cache_mem_arbiter_pkg;

  // Default word-address width of the external memory port.
  localparam int BW_WORD_ADDR = 24;

  // Arbiter phases: waiting for a request, owning the port, one dead cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Requester identities.
  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  // Bit positions inside exception_o.
  localparam int EXC_OVERRUN = 0;
  localparam int EXC_TIMEOUT = 1;

  // Turn a requester id into its one-hot grant vector.
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_select.sv
// Two-way round-robin pick: when both caches request, the one that was not
// served last wins; otherwise the single requester wins.
module mem_arb_rr_select
  import cache_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick,
  output logic       id,
  output logic       valid
);

  // Choose the winning requester and express it both as id and one-hot.
  always_comb begin
    valid = |req;
    id    = REQ_INST;
    if (req == 2'b11) begin
      id = ~last;
    end else if (req[REQ_DATA]) begin
      id = REQ_DATA;
    end
    pick = valid ? id_to_onehot(id) : 2'b00;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the external memory port between the instruction cache (0) and the
// data cache (1). One transaction at a time, round-robin between them; the
// owner keeps the port until the memory signals completion or the watchdog
// gives up. Overrun and timeout events are kept as sticky exception bits.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int BW_ADDR     = BW_WORD_ADDR,
  parameter int BLOCK_WORDS = 16,
  parameter int TIMEOUT     = 4095
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [1:0]         req_i,
  input  logic [1:0]         block_i,
  input  logic [1:0]         rw_i,
  input  logic [BW_ADDR-1:0] add0_i,
  input  logic [BW_ADDR-1:0] add1_i,
  input  logic [31:0]        wdata0_i,
  input  logic [31:0]        wdata1_i,
  output logic [1:0]         grant_o,
  output logic [1:0]         wr_accept_o,
  output logic [1:0]         rd_valid_o,
  output logic [31:0]        rdata_o,
  output logic [1:0]         done_o,
  output logic               mem_req_o,
  output logic               mem_reqBlock_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic [31:0]        mem_data_o,
  input  logic [31:0]        mem_data_i,
  input  logic               mem_ready_i,
  input  logic               mem_valid_i,
  input  logic               mem_done_i,
  output logic [1:0]         exception_o
);

  // The word counter needs one spare bit so that BLOCK_WORDS itself fits.
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
  localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] BLOCK_LIMIT = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] SINGLE_LIMIT = CNT_W'(1);
  // The watchdog aborts on the edge that closes the TIMEOUT-th idle cycle.
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t         state_reg;
  logic               last_reg;
  logic               id_reg;
  logic [1:0]         grant_reg;
  logic               mem_req_reg;
  logic               block_reg;
  logic               rw_reg;
  logic [BW_ADDR-1:0] add_reg;
  logic [1:0]         done_reg;
  logic [1:0]         rd_valid_reg;
  logic [31:0]        rdata_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [WD_W-1:0]    wd_cnt_reg;
  logic [1:0]         exc_reg;

  logic [1:0]         sel_pick;
  logic               sel_id;
  logic               sel_valid;

  logic               busy;
  logic               word_ev;
  logic               activity;
  logic [CNT_W-1:0]   word_limit;
  logic               overrun;
  logic               timeout_hit;
  logic [31:0]        mem_data_mux;

  mem_arb_rr_select u_rr_select (
    .req   (req_i),
    .last  (last_reg),
    .pick  (sel_pick),
    .id    (sel_id),
    .valid (sel_valid)
  );

  // Per-transaction events: a word moves in the owner's direction, the
  // watchdog sees any memory handshake, and overrun fires on the word after
  // the counter has already reached the transfer length.
  always_comb begin
    busy        = (state_reg == ST_BUSY);
    word_ev     = busy & (rw_reg ? mem_ready_i : mem_valid_i);
    activity    = mem_ready_i | mem_valid_i | mem_done_i;
    word_limit  = block_reg ? BLOCK_LIMIT : SINGLE_LIMIT;
    overrun     = word_ev & (word_cnt_reg == word_limit);
    timeout_hit = busy & ~activity & (wd_cnt_reg == WD_LAST);
  end

  // Arbitration FSM with registered grant, request, latch and done outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg    <= ST_IDLE;
      last_reg     <= REQ_DATA;
      id_reg       <= REQ_INST;
      grant_reg    <= 2'b00;
      mem_req_reg  <= 1'b0;
      block_reg    <= 1'b0;
      rw_reg       <= 1'b0;
      add_reg      <= '0;
      done_reg     <= 2'b00;
      word_cnt_reg <= '0;
      wd_cnt_reg   <= '0;
      exc_reg      <= 2'b00;
    end else begin
      done_reg <= 2'b00;
      case (state_reg)
        ST_IDLE: begin
          if (sel_valid) begin
            id_reg       <= sel_id;
            grant_reg    <= sel_pick;
            mem_req_reg  <= 1'b1;
            block_reg    <= block_i[sel_id];
            rw_reg       <= rw_i[sel_id];
            add_reg      <= sel_id ? add1_i : add0_i;
            word_cnt_reg <= '0;
            wd_cnt_reg   <= '0;
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The counter saturates at the limit; extra words only flag overrun.
          if (overrun) begin
            exc_reg[EXC_OVERRUN] <= 1'b1;
          end else if (word_ev) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
          end
          if (activity) begin
            wd_cnt_reg <= '0;
          end else if (!timeout_hit) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
          // Completion and watchdog abort both release the port the same way.
          if (mem_done_i || timeout_hit) begin
            if (timeout_hit) begin
              exc_reg[EXC_TIMEOUT] <= 1'b1;
            end
            grant_reg   <= 2'b00;
            mem_req_reg <= 1'b0;
            block_reg   <= 1'b0;
            rw_reg      <= 1'b0;
            add_reg     <= '0;
            done_reg    <= grant_reg;
            last_reg    <= id_reg;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Read words are forwarded one cycle late, tagged for the owner only.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_valid_reg <= 2'b00;
      rdata_reg    <= '0;
    end else begin
      rd_valid_reg <= 2'b00;
      if (busy && !rw_reg && mem_valid_i) begin
        rd_valid_reg <= grant_reg;
        rdata_reg    <= mem_data_i;
      end
    end
  end

  // Write data follows the registered grant with no extra latency.
  always_comb begin
    mem_data_mux = '0;
    if (grant_reg[REQ_DATA]) begin
      mem_data_mux = wdata1_i;
    end else if (grant_reg[REQ_INST]) begin
      mem_data_mux = wdata0_i;
    end
  end

  // Each requester sees its own same-cycle write acknowledge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_wr_accept
    assign wr_accept_o[gi] = busy & rw_reg & grant_reg[gi] & mem_ready_i;
  end

  assign grant_o        = grant_reg;
  assign rd_valid_o     = rd_valid_reg;
  assign rdata_o        = rdata_reg;
  assign done_o         = done_reg;
  assign mem_req_o      = mem_req_reg;
  assign mem_reqBlock_o = block_reg;
  assign mem_rw_o       = rw_reg;
  assign mem_add_o      = add_reg;
  assign mem_data_o     = mem_data_mux;
  assign exception_o    = exc_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations
// plus a transaction-level model checked against the outputs every cycle.
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int BW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, block, rw;
  logic [AW-1:0] add0, add1;
  logic [31:0]   wdata0, wdata1;
  logic [1:0]    grant, wr_accept, rd_valid, done, exception;
  logic [31:0]   rdata, mem_data_o, mem_data_i;
  logic          mem_req, mem_block, mem_rw;
  logic [AW-1:0] mem_add;
  logic          mem_ready, mem_valid, mem_done;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.BW_ADDR(AW), .BLOCK_WORDS(BW), .TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .block_i(block), .rw_i(rw),
    .add0_i(add0), .add1_i(add1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .grant_o(grant), .wr_accept_o(wr_accept), .rd_valid_o(rd_valid),
    .rdata_o(rdata), .done_o(done), .mem_req_o(mem_req),
    .mem_reqBlock_o(mem_block), .mem_rw_o(mem_rw), .mem_add_o(mem_add),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ready_i(mem_ready),
    .mem_valid_i(mem_valid), .mem_done_i(mem_done), .exception_o(exception)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, what was latched, how many
  // words and idle cycles have elapsed, and which pulses are due next cycle.
  bit            model_ok = 0;
  int            m_owner, m_last, m_words, m_idle;
  bit            m_cool, m_block, m_rw;
  logic [AW-1:0] m_add;
  logic [1:0]    m_exc, e_done, e_rdv;
  logic [31:0]   e_rdata;
  int            n_rdv0 = 0;
  int            n_done = 0;

  // At each falling edge: compare outputs with the model, then advance the
  // model with the inputs the DUT will sample at the coming rising edge.
  always @(negedge clk) begin
    logic [1:0] eg;
    if (model_ok) begin
      eg = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
      chk("grant", grant, eg);
      chk("mem_req", mem_req, m_owner >= 0);
      chk("mem_add", mem_add, (m_owner >= 0) ? m_add : '0);
      chk("mem_block", mem_block, (m_owner >= 0) && m_block);
      chk("mem_rw", mem_rw, (m_owner >= 0) && m_rw);
      chk("wr_accept", wr_accept, (m_owner >= 0 && m_rw && mem_ready) ? eg : 2'b00);
      if (m_owner >= 0 && m_rw)
        chk("mem_data_o", mem_data_o, (m_owner == 1) ? wdata1 : wdata0);
      chk("rd_valid", rd_valid, e_rdv);
      if (e_rdv != 2'b00) chk("rdata", rdata, e_rdata);
      chk("done", done, e_done);
      chk("exception", exception, m_exc);
    end
    if (rd_valid[0]) n_rdv0++;
    if (done != 2'b00) n_done++;

    if (rst) begin
      model_ok = 1; m_owner = -1; m_last = 1; m_cool = 0; m_words = 0; m_idle = 0;
      m_block = 0; m_rw = 0; m_add = '0; m_exc = 2'b00;
      e_done = 2'b00; e_rdv = 2'b00; e_rdata = '0;
    end else if (model_ok) begin
      e_done = 2'b00;
      e_rdv = 2'b00;
      if (m_owner >= 0) begin
        if (!m_rw && mem_valid) begin
          e_rdv = 2'(1 << m_owner);
          e_rdata = mem_data_i;
        end
        if (m_rw ? mem_ready : mem_valid) begin
          m_words++;
          if (m_words > (m_block ? BW : 1)) m_exc[0] = 1'b1;
        end
        if (mem_ready || mem_valid || mem_done) m_idle = 0;
        else m_idle++;
        if (mem_done || m_idle == TO) begin
          if (!mem_done) m_exc[1] = 1'b1;
          e_done = 2'(1 << m_owner);
          m_last = m_owner;
          m_owner = -1;
          m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
        else m_owner = req[1] ? 1 : 0;
        m_block = block[m_owner];
        m_rw = rw[m_owner];
        m_add = (m_owner == 1) ? add1 : add0;
        m_words = 0;
        m_idle = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; block = 0; rw = 0; add0 = 0; add1 = 0; wdata0 = 0; wdata1 = 0;
    mem_data_i = 0; mem_ready = 0; mem_valid = 0; mem_done = 0;
    tick(3);
    rst = 0;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (grant == 2'b00 && waited < 20) begin
      tick(1);
      waited++;
    end
    if (grant == 2'b00) begin
      failures++;
      $display("FAIL wait_grant actual=timeout required=grant");
    end
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int w, base_rdv, base_done;
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_exception", exception, 2'b00);
    chk("rst_rdata", rdata, 32'h0);

    // 1: block read by requester 0, 16 words then done.
    base_rdv = n_rdv0; base_done = n_done;
    req = 2'b01; block = 2'b01; rw = 2'b00; add0 = 16'h0040;
    tick(1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_mem_add", mem_add, 16'h0040);
    for (int i = 0; i < 16; i++) begin
      mem_valid = 1; mem_data_i = 32'h1000 + i;
      tick(1);
      chk("t1_rdata", rdata, 32'h1000 + i);
    end
    mem_valid = 0; mem_done = 1;
    tick(1);
    mem_done = 0;
    chk("t1_done", done, 2'b01);
    req = 2'b00;
    tick(2);
    chk("t1_rdv_count", n_rdv0 - base_rdv, 16);
    chk("t1_done_count", n_done - base_done, 1);
    chk("t1_exception", exception, 2'b00);

    // 2: both request, four single reads -> alternate 0,1,0,1.
    do_reset();
    req = 2'b11; block = 2'b00; rw = 2'b00;
    for (int t = 0; t < 4; t++) begin
      wait_grant(w);
      chk("t2_grant", grant, exp_g[t]);
      chk("t2_gap", w, (t == 0) ? 1 : 2);
      mem_valid = 1; mem_done = 1; mem_data_i = 32'hA0 + t;
      tick(1);
      mem_valid = 0; mem_done = 0;
      chk("t2_done", done, exp_g[t]);
      if (t == 3) req = 2'b00;
    end
    tick(2);

    // 3: single write from requester 1, ready in the third granted cycle.
    do_reset();
    req = 2'b10; rw = 2'b10; block = 2'b00; add0 = 16'h00AA; add1 = 16'h0123;
    wdata0 = 32'h11111111; wdata1 = 32'hDEADBEEF;
    wait_grant(w);
    chk("t3_add_c1", mem_add, 16'h0123);
    tick(1);
    chk("t3_add_c2", mem_add, 16'h0123);
    chk("t3_accept_idle", wr_accept, 2'b00);
    tick(1);
    mem_ready = 1;
    #1;
    chk("t3_mem_data", mem_data_o, 32'hDEADBEEF);
    chk("t3_wr_accept", wr_accept, 2'b10);
    chk("t3_add_c3", mem_add, 16'h0123);
    chk("t3_mem_rw", mem_rw, 1'b1);
    tick(1);
    mem_ready = 0; mem_done = 1;
    tick(1);
    mem_done = 0;
    chk("t3_done", done, 2'b10);
    req = 2'b00;
    tick(2);
    chk("t3_exception", exception, 2'b00);

    // 4: block read with 17 words -> overrun flag after the 17th, sticky.
    do_reset();
    req = 2'b01; block = 2'b01; rw = 2'b00; add0 = 16'h0200;
    wait_grant(w);
    for (int i = 0; i < 17; i++) begin
      mem_valid = 1; mem_data_i = 32'h2000 + i;
      tick(1);
      if (i == 15) chk("t4_exc_word16", exception, 2'b00);
      if (i == 16) chk("t4_exc_word17", exception, 2'b01);
    end
    chk("t4_word17_fwd", rdata, 32'h2010);
    mem_valid = 0; mem_done = 1;
    tick(1);
    mem_done = 0;
    chk("t4_done", done, 2'b01);
    req = 2'b00;
    tick(3);
    chk("t4_sticky", exception, 2'b01);

    // 5: no memory response -> watchdog abort after 8 idle cycles.
    do_reset();
    req = 2'b01; block = 2'b00; rw = 2'b00;
    wait_grant(w);
    tick(7);
    chk("t5_exc_before", exception, 2'b00);
    chk("t5_req_before", mem_req, 1'b1);
    tick(1);
    chk("t5_exc", exception, 2'b10);
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_done", done, 2'b01);
    req = 2'b00;
    tick(3);
    chk("t5_sticky", exception, 2'b10);

    // 6: reset during word 5 of a block read -> silent abort; fresh 11 grants 0.
    do_reset();
    req = 2'b01; block = 2'b01; rw = 2'b00; add0 = 16'h0300;
    wait_grant(w);
    base_done = n_done;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; mem_data_i = 32'h3000 + i;
      tick(1);
    end
    mem_data_i = 32'h3004; rst = 1;
    tick(1);
    rst = 0; mem_valid = 0; req = 2'b11;
    chk("t6_grant", grant, 2'b00);
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_rd_valid", rd_valid, 2'b00);
    chk("t6_done", done, 2'b00);
    wait_grant(w);
    chk("t6_fresh_grant", grant, 2'b01);
    chk("t6_no_done", n_done - base_done, 0);
    mem_valid = 1; mem_done = 1; mem_data_i = 32'h3100;
    tick(1);
    mem_valid = 0; mem_done = 0; req = 2'b00;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
